// File: rtl/gpmc_sram_arbiter_pkg.sv
// Shared defaults for the GPMC/fabric SRAM arbiter: widths, host port index, sizing helper.
// Pure declarations; no logic, no latency, no flow control.
package gpmc_sram_arbiter_pkg;

    localparam int DEF_NREQ       = 3;
    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_HOST_BURST = 4;
    localparam int HOST_PORT      = 0;

    // Counter/index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gpmc_sram_arbiter_rr_pick.sv
// Rotating-priority picker: lowest set bit of i_vec at or after i_ptr, cyclically, as one-hot.
// Purely combinational, zero latency; never grants an unrequested bit.
import gpmc_sram_arbiter_pkg::*;

module gpmc_sram_arbiter_rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     i_vec,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt
);

    logic [N-1:0] w_rot;
    logic [N-1:0] w_rot_oh;

    // Rotate so i_ptr sits at bit 0, isolate the lowest set bit, rotate back.
    assign w_rot    = N'({i_vec, i_vec} >> i_ptr);
    assign w_rot_oh = w_rot & (-w_rot);
    assign o_gnt    = N'(({w_rot_oh, w_rot_oh} << i_ptr) >> N);

endmodule

// File: rtl/gpmc_sram_arbiter.sv
// Arbitrates one single-port RAM between host port 0 (bounded priority) and round-robin fabric ports.
// Grant is combinational; RAM command one cycle later, read data two cycles after grant; losers hold REQ.
import gpmc_sram_arbiter_pkg::*;

module gpmc_sram_arbiter #(
    parameter int NREQ       = DEF_NREQ,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int HOST_BURST = DEF_HOST_BURST
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NREQ-1:0]            i_req,
    input  logic [NREQ-1:0]            i_we,
    input  logic [NREQ*ADDR_W-1:0]     i_addr,
    input  logic [NREQ*DATA_W-1:0]     i_wdata,
    input  logic [NREQ*(DATA_W/8)-1:0] i_be,
    input  logic                       i_wp,
    output logic [NREQ-1:0]            o_gnt,
    output logic [NREQ-1:0]            o_rvalid,
    output logic [DATA_W-1:0]          o_rdata,
    output logic                       o_wp_viol,
    output logic                       o_sram_en,
    output logic [DATA_W/8-1:0]        o_sram_we,
    output logic [ADDR_W-1:0]          o_sram_addr,
    output logic [DATA_W-1:0]          o_sram_wdata,
    input  logic [DATA_W-1:0]          i_sram_rdata
);

    localparam int BE_W = DATA_W / 8;
    localparam int PW   = clog2_min1(NREQ);
    localparam int CW   = clog2_min1(HOST_BURST + 1);

    logic [PW-1:0]     r_rr_ptr;
    logic [CW-1:0]     r_host_cnt;
    logic              r_rd1_vld;
    logic [PW-1:0]     r_rd1_idx;
    logic [NREQ-1:0]   r_rvalid;
    logic              r_wp_viol;
    logic              r_sram_en;
    logic [BE_W-1:0]   r_sram_we;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [DATA_W-1:0] r_sram_wdata;

    logic              w_fab_pend;
    logic              w_host_win;
    logic              w_wp_block;
    logic [NREQ-2:0]   w_fab_oh;
    logic [NREQ-1:0]   w_gnt;
    logic [PW-1:0]     w_win;
    logic [PW-1:0]     w_rr_next;

    assign w_fab_pend = |i_req[NREQ-1:1];
    assign w_host_win = i_req[HOST_PORT] && ((r_host_cnt < CW'(HOST_BURST)) || !w_fab_pend);

    gpmc_sram_arbiter_rr_pick #(
        .N     (NREQ - 1),
        .PTR_W (PW)
    ) u_rr_pick (
        .i_vec (i_req[NREQ-1:1]),
        .i_ptr (r_rr_ptr - PW'(1)),
        .o_gnt (w_fab_oh)
    );

    always_comb begin
        w_gnt = '0;
        if (!i_rst) begin
            if (w_host_win) w_gnt[HOST_PORT] = 1'b1;
            else            w_gnt = {w_fab_oh, 1'b0};
        end
    end

    always_comb begin
        w_win = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) w_win = PW'(i);
        end
    end

    assign w_wp_block = w_gnt[HOST_PORT] && i_we[HOST_PORT] && i_wp;
    assign w_rr_next  = (w_win == PW'(NREQ - 1)) ? PW'(1) : w_win + PW'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr     <= PW'(1);
            r_host_cnt   <= '0;
            r_rd1_vld    <= 1'b0;
            r_rd1_idx    <= '0;
            r_rvalid     <= '0;
            r_wp_viol    <= 1'b0;
            r_sram_en    <= 1'b0;
            r_sram_we    <= '0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
        end else begin
            if (!w_fab_pend) begin
                r_host_cnt <= '0;
            end else if (w_gnt[HOST_PORT]) begin
                if (r_host_cnt != CW'(HOST_BURST)) r_host_cnt <= r_host_cnt + CW'(1);
            end else begin
                r_host_cnt <= '0;
            end

            if (|w_gnt[NREQ-1:1]) r_rr_ptr <= w_rr_next;

            // A write-protected host write is consumed but never reaches the RAM.
            r_sram_en <= 1'b0;
            r_sram_we <= '0;
            if ((|w_gnt) && !w_wp_block) begin
                r_sram_en    <= 1'b1;
                r_sram_addr  <= i_addr[w_win*ADDR_W +: ADDR_W];
                r_sram_wdata <= i_wdata[w_win*DATA_W +: DATA_W];
                r_sram_we    <= i_we[w_win] ? i_be[w_win*BE_W +: BE_W] : '0;
            end
            if (w_wp_block) r_wp_viol <= 1'b1;

            r_rd1_vld <= (|w_gnt) && !i_we[w_win];
            r_rd1_idx <= w_win;
            r_rvalid  <= r_rd1_vld ? (NREQ'(1) << r_rd1_idx) : '0;
        end
    end

    assign o_gnt        = w_gnt;
    assign o_rvalid     = r_rvalid;
    assign o_rdata      = (|r_rvalid) ? i_sram_rdata : '0;
    assign o_wp_viol    = r_wp_viol;
    assign o_sram_en    = r_sram_en;
    assign o_sram_we    = r_sram_we;
    assign o_sram_addr  = r_sram_addr;
    assign o_sram_wdata = r_sram_wdata;

endmodule
